// File: rtl/btn_conditioner_pkg.sv
// btn_conditioner_pkg: shared button indices, button word type and SOCD cleaning helper
package btn_conditioner_pkg;
  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_UP    = 2;
  localparam int BTN_DOWN  = 3;
  localparam int BTN_JUMP  = 4;
  localparam int BTN_DASH  = 5;
  typedef logic [5:0] btn_t;
  // Opposing directions held together cancel out, so the core never sees L+R or U+D.
  function automatic btn_t socd_clean(btn_t b);
    btn_t r;
    r = b;
    if (b[BTN_LEFT] && b[BTN_RIGHT]) begin
      r[BTN_LEFT]  = 1'b0;
      r[BTN_RIGHT] = 1'b0;
    end
    if (b[BTN_UP] && b[BTN_DOWN]) begin
      r[BTN_UP]   = 1'b0;
      r[BTN_DOWN] = 1'b0;
    end
    return r;
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus stability counter for one raw button pin
module btn_debounce
  import btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic pad_i,
  output logic deb_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic sync1_q, sync2_q, deb_q, deb_d, differ, hit;
  logic [CW-1:0] cnt_q, cnt_d;
  // Count consecutive cycles the synchronized pin disagrees with the accepted state; accept on the last one.
  always_comb begin
    differ = sync2_q != deb_q;
    hit    = differ && (cnt_q == LAST);
    cnt_d  = (!differ || hit) ? '0 : cnt_q + 1'b1;
    deb_d  = hit ? sync2_q : deb_q;
  end
  // Synchronizer stages, counter and accepted state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pad_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end
  assign deb_o = deb_q;
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: debounced, frame-latched button word with press edges and jump buffer (optional BTN_SOCD_EN)
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int JUMP_BUF_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] pad_raw,
  input  logic       frame_tick,
  output logic [5:0] btn,
  output logic       jump_press,
  output logic       dash_press,
  output logic       jump_buf,
  output logic       frame_valid
);
  btn_t deb_w, latch_d, btn_q;
  logic jp_d, dp_d, jp_q, dp_q, fv_q;
  logic [3:0] jcnt_q, jcnt_d;
  for (genvar i = 0; i < 6; i++) begin : g_deb
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk  (clk),
      .rst  (rst),
      .pad_i(pad_raw[i]),
      .deb_o(deb_w[i])
    );
  end
  // Word to latch this frame, its rising edges against the previous frame, and next buffer count.
  always_comb begin
`ifdef BTN_SOCD_EN
    latch_d = socd_clean(deb_w);
`else
    latch_d = deb_w;
`endif
    jp_d   = latch_d[BTN_JUMP] & ~btn_q[BTN_JUMP];
    dp_d   = latch_d[BTN_DASH] & ~btn_q[BTN_DASH];
    jcnt_d = jp_d ? 4'(JUMP_BUF_FRAMES) : (jcnt_q != 4'd0 ? jcnt_q - 4'd1 : jcnt_q);
  end
  // Frame latch: button word and buffer hold between ticks; strobes last one cycle after a tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_q  <= '0;
      jp_q   <= 1'b0;
      dp_q   <= 1'b0;
      fv_q   <= 1'b0;
      jcnt_q <= '0;
    end else begin
      fv_q <= frame_tick;
      jp_q <= frame_tick & jp_d;
      dp_q <= frame_tick & dp_d;
      if (frame_tick) begin
        btn_q  <= latch_d;
        jcnt_q <= jcnt_d;
      end
    end
  end
  assign btn         = btn_q;
  assign jump_press  = jp_q;
  assign dash_press  = dp_q;
  assign jump_buf    = |jcnt_q;
  assign frame_valid = fv_q;
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed checks of reset, debounce, glitch rejection, frame hold, jump buffer and async reset
module tb_btn_conditioner;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [5:0] pad_raw = 6'h3F;
  logic frame_tick = 1'b0;
  logic [5:0] btn;
  logic jump_press, dash_press, jump_buf, frame_valid;
  int n_cmp = 0;
  int n_err = 0;
  btn_conditioner #(.DEBOUNCE_CYCLES(4), .JUMP_BUF_FRAMES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .pad_raw    (pad_raw),
    .frame_tick (frame_tick),
    .btn        (btn),
    .jump_press (jump_press),
    .dash_press (dash_press),
    .jump_buf   (jump_buf),
    .frame_valid(frame_valid)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic tick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    step(3);
    chk("rst_btn", 8'(btn), 8'h00);
    chk("rst_jp", 8'(jump_press), 8'h0);
    chk("rst_dp", 8'(dash_press), 8'h0);
    chk("rst_jbuf", 8'(jump_buf), 8'h0);
    chk("rst_fv", 8'(frame_valid), 8'h0);
    frame_tick = 1'b1;
    step(10);
    chk("rst_hold_btn", 8'(btn), 8'h00);
    chk("rst_hold_fv", 8'(frame_valid), 8'h0);
    pad_raw = 6'h00;
    rst = 1'b1;
    step(8);
    chk("idle_btn", 8'(btn), 8'h00);
    chk("idle_fv", 8'(frame_valid), 8'h1);
    pad_raw[4] = 1'b1;
    step(6);
    chk("deb_early_btn", 8'(btn), 8'h00);
    step(1);
    chk("deb_btn", 8'(btn), 8'h10);
    chk("deb_jp", 8'(jump_press), 8'h1);
    chk("deb_jbuf", 8'(jump_buf), 8'h1);
    step(1);
    chk("deb_jp_once", 8'(jump_press), 8'h0);
    chk("deb_btn_hold", 8'(btn), 8'h10);
    pad_raw[4] = 1'b0;
    step(2);
    chk("jbuf_f3", 8'(jump_buf), 8'h1);
    step(1);
    chk("jbuf_f4", 8'(jump_buf), 8'h0);
    step(10);
    chk("rel_btn", 8'(btn), 8'h00);
    pad_raw[0] = 1'b1;
    step(3);
    pad_raw[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("glitch_btn", 8'(btn), 8'h00);
      step(1);
    end
    frame_tick = 1'b0;
    step(2);
    pad_raw[5] = 1'b1;
    step(3);
    chk("fh_mid_btn", 8'(btn), 8'h00);
    chk("fh_mid_fv", 8'(frame_valid), 8'h0);
    step(3);
    chk("fh_deb_btn", 8'(btn), 8'h00);
    chk("fh_deb_dp", 8'(dash_press), 8'h0);
    tick();
    chk("fh_btn", 8'(btn), 8'h20);
    chk("fh_dp", 8'(dash_press), 8'h1);
    chk("fh_fv", 8'(frame_valid), 8'h1);
    step(1);
    chk("fh_dp_off", 8'(dash_press), 8'h0);
    chk("fh_fv_off", 8'(frame_valid), 8'h0);
    chk("fh_btn_hold", 8'(btn), 8'h20);
    step(8);
    tick();
    chk("fh2_btn", 8'(btn), 8'h20);
    chk("fh2_dp", 8'(dash_press), 8'h0);
    chk("fh2_fv", 8'(frame_valid), 8'h1);
    pad_raw = 6'h10;
    step(8);
    tick();
    chk("br_f0_jp", 8'(jump_press), 8'h1);
    chk("br_f0_btn", 8'(btn), 8'h10);
    pad_raw[4] = 1'b0;
    step(8);
    tick();
    chk("br_f1_btn", 8'(btn), 8'h00);
    chk("br_f1_jbuf", 8'(jump_buf), 8'h1);
    pad_raw[4] = 1'b1;
    step(8);
    tick();
    chk("br_f2_jp", 8'(jump_press), 8'h1);
    step(2);
    tick();
    chk("br_f3_jbuf", 8'(jump_buf), 8'h1);
    step(2);
    tick();
    chk("br_f4_jbuf", 8'(jump_buf), 8'h1);
    step(2);
    tick();
    chk("br_f5_jbuf", 8'(jump_buf), 8'h1);
    chk("br_f5_jp", 8'(jump_press), 8'h0);
    step(2);
    tick();
    chk("br_f6_jbuf", 8'(jump_buf), 8'h0);
    pad_raw[4] = 1'b0;
    step(8);
    tick();
    pad_raw[4] = 1'b1;
    step(8);
    tick();
    chk("ar_pre_jbuf", 8'(jump_buf), 8'h1);
    rst = 1'b0;
    #2;
    chk("ar_jbuf", 8'(jump_buf), 8'h0);
    chk("ar_btn", 8'(btn), 8'h00);
    chk("ar_jp", 8'(jump_press), 8'h0);
    step(2);
    chk("ar_hold_btn", 8'(btn), 8'h00);
    frame_tick = 1'b1;
    rst = 1'b1;
    step(6);
    chk("ar_rel_btn", 8'(btn), 8'h00);
    chk("ar_rel_fv", 8'(frame_valid), 8'h1);
    step(1);
    chk("ar_rel_btn2", 8'(btn), 8'h10);
    chk("ar_rel_jp", 8'(jump_press), 8'h1);
    pad_raw = 6'b000011;
    step(10);
`ifdef BTN_SOCD_EN
    chk("socd_btn", 8'(btn), 8'h00);
`else
    chk("socd_btn", 8'(btn), 8'h03);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
